// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared defaults for the fixed-point ALU command path and the opcode map.
//   The operand format is signed Q(INT_W).(FRAC_W), packed into DATA_W bits.
package alu_pkg;

   localparam int INT_W  = 3;
   localparam int FRAC_W = 5;
   localparam int INST_W = 3;
   localparam int DATA_W = INT_W + FRAC_W;

   localparam logic [INST_W-1:0] ADD     = 3'd0;
   localparam logic [INST_W-1:0] SUB     = 3'd1;
   localparam logic [INST_W-1:0] MUL     = 3'd2;
   localparam logic [INST_W-1:0] NAND    = 3'd3;
   localparam logic [INST_W-1:0] XNOR    = 3'd4;
   localparam logic [INST_W-1:0] SIGMOID = 3'd5;
   localparam logic [INST_W-1:0] ROT     = 3'd6;
   localparam logic [INST_W-1:0] MIN     = 3'd7;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock show-ahead FIFO. The head entry is visible on o_data while
//   o_empty is low; it is consumed by i_pop. Push into a full FIFO and pop
//   from an empty FIFO are ignored. Simultaneous push and pop both take
//   effect and leave the count unchanged.
// Ports
//   i_clk, i_rst       : clock, synchronous active-high reset (empties FIFO)
//   i_push, i_data     : write request and data
//   i_pop              : consume head entry
//   o_data             : head entry (undefined content when empty)
//   o_empty            : no entries held
//   o_count            : number of entries held, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_push;
   logic w_pop;

   assign w_push = i_push && (r_count != (AW+1)'(DEPTH));
   assign w_pop  = i_pop && (r_count != '0);

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // DEPTH is a power of two, so pointer increment wraps modulo DEPTH.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Queues ALU commands, issues them one per cycle to an external ALU with a
//   fixed one-cycle latency, captures each result with its opcode tag and
//   presents results downstream in acceptance order.
// Ports
//   i_clk, i_rst                    : clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready       : upstream command handshake
//   i_cmd_inst, i_cmd_a, i_cmd_b    : opcode and signed fixed-point operands
//   o_alu_valid, o_alu_inst/a/b     : issue to the ALU (data zero when idle)
//   i_alu_valid, i_alu_data         : registered ALU result, free-running valid
//   o_res_valid / i_res_ready       : downstream result handshake
//   o_res_data, o_res_inst          : result and the opcode that produced it
//   o_err                           : sticky, set when an expected result is missing
module alu_cmd_issuer #(
   parameter int INT_W  = alu_pkg::INT_W,
   parameter int FRAC_W = alu_pkg::FRAC_W,
   parameter int INST_W = alu_pkg::INST_W,
   parameter int DATA_W = INT_W + FRAC_W,
   parameter int DEPTH  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [INST_W-1:0] i_cmd_inst,
   input  logic [DATA_W-1:0] i_cmd_a,
   input  logic [DATA_W-1:0] i_cmd_b,
   output logic              o_alu_valid,
   output logic [INST_W-1:0] o_alu_inst,
   output logic [DATA_W-1:0] o_alu_a,
   output logic [DATA_W-1:0] o_alu_b,
   input  logic              i_alu_valid,
   input  logic [DATA_W-1:0] i_alu_data,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [DATA_W-1:0] o_res_data,
   output logic [INST_W-1:0] o_res_inst,
   output logic              o_err
);

   import alu_pkg::*;

   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int CMD_W = INST_W + 2 * DATA_W;
   localparam int RES_W = DATA_W + INST_W;

   // Command FIFO
   logic             w_cmd_push;
   logic             w_cmd_empty;
   logic [CW-1:0]    w_cmd_count;
   logic [CMD_W-1:0] w_cmd_head;

   // Result FIFO
   logic             w_res_push;
   logic             w_res_pop;
   logic             w_res_empty;
   logic [CW-1:0]    w_res_count;
   logic [RES_W-1:0] w_res_head;

   logic             w_issue;
   logic [CW:0]      w_res_occ;

   logic              r_inflight;
   logic [INST_W-1:0] r_tag;
   logic              r_err;

   // Ready uses the registered count only: a pop in the same cycle does not
   // open a slot until the next cycle.
   assign o_cmd_ready = (w_cmd_count < CW'(DEPTH));
   assign w_cmd_push  = i_cmd_valid && o_cmd_ready;

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_cmd_push),
      .i_data  ({i_cmd_inst, i_cmd_a, i_cmd_b}),
      .i_pop   (w_issue),
      .o_data  (w_cmd_head),
      .o_empty (w_cmd_empty),
      .o_count (w_cmd_count)
   );

   // Reserve a result slot for the command in flight so a result can never
   // arrive to a full result FIFO.
   assign w_res_occ = {1'b0, w_res_count} + (CW+1)'(r_inflight);
   assign w_issue   = !w_cmd_empty && (w_res_occ < (CW+1)'(DEPTH));

   assign o_alu_valid = w_issue;
   assign o_alu_inst  = w_issue ? w_cmd_head[CMD_W-1 -: INST_W]          : '0;
   assign o_alu_a     = w_issue ? w_cmd_head[2*DATA_W-1 -: DATA_W]       : '0;
   assign o_alu_b     = w_issue ? w_cmd_head[DATA_W-1:0]                 : '0;

   // ALU latency is exactly one cycle, so a single flag plus tag tracks the
   // outstanding operation; i_alu_valid is only meaningful while it is set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inflight <= 1'b0;
         r_tag      <= '0;
         r_err      <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_tag      <= o_alu_inst;
         if (r_inflight && !i_alu_valid) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_res_push = r_inflight && i_alu_valid;
   assign w_res_pop  = !w_res_empty && i_res_ready;

   sync_fifo #(
      .WIDTH (RES_W),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_res_push),
      .i_data  ({i_alu_data, r_tag}),
      .i_pop   (w_res_pop),
      .o_data  (w_res_head),
      .o_empty (w_res_empty),
      .o_count (w_res_count)
   );

   // Storage is not reset, so gate the head to keep outputs zero when idle.
   assign o_res_valid = !w_res_empty;
   assign o_res_data  = o_res_valid ? w_res_head[RES_W-1 -: DATA_W] : '0;
   assign o_res_inst  = o_res_valid ? w_res_head[INST_W-1:0]        : '0;
   assign o_err       = r_err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_cmd_valid;
   logic       o_cmd_ready;
   logic [2:0] i_cmd_inst;
   logic [7:0] i_cmd_a;
   logic [7:0] i_cmd_b;
   logic       o_alu_valid;
   logic [2:0] o_alu_inst;
   logic [7:0] o_alu_a;
   logic [7:0] o_alu_b;
   logic       i_alu_valid;
   logic [7:0] i_alu_data;
   logic       o_res_valid;
   logic       i_res_ready;
   logic [7:0] o_res_data;
   logic [2:0] o_res_inst;
   logic       o_err;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;
   int n_iss   = 0;

   logic [10:0] exp_q[$];
   logic [10:0] log_q[$];

   always #5 clk = ~clk;

   alu_cmd_issuer dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_inst  (i_cmd_inst),
      .i_cmd_a     (i_cmd_a),
      .i_cmd_b     (i_cmd_b),
      .o_alu_valid (o_alu_valid),
      .o_alu_inst  (o_alu_inst),
      .o_alu_a     (o_alu_a),
      .o_alu_b     (o_alu_b),
      .i_alu_valid (i_alu_valid),
      .i_alu_data  (i_alu_data),
      .o_res_valid (o_res_valid),
      .i_res_ready (i_res_ready),
      .o_res_data  (o_res_data),
      .o_res_inst  (o_res_inst),
      .o_err       (o_err)
   );

   // Behavioural Q3.5 ALU: saturating signed arithmetic.
   function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      int sa;
      int sb;
      int r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         ADD:     r = sa + sb;
         SUB:     r = sa - sb;
         MUL:     r = (sa * sb) >>> FRAC_W;
         NAND:    return ~(a & b);
         XNOR:    return ~(a ^ b);
         SIGMOID: r = (sa < 0) ? 0 : 32;
         ROT:     return {a[6:0], a[7]};
         default: r = (sa < sb) ? sa : sb;
      endcase
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return 8'(r);
   endfunction

   // External ALU, one-cycle registered latency; valid/data are garbage
   // whenever nothing was issued the cycle before.
   logic       m_v     = 1'b0;
   logic [7:0] m_d     = 8'h00;
   logic       kill    = 1'b0;
   logic       force_v = 1'b0;

   always @(posedge clk) begin
      if (o_alu_valid) begin
         m_v <= 1'b1;
         m_d <= alu_fn(o_alu_inst, o_alu_a, o_alu_b);
      end else begin
         m_v <= 1'($urandom_range(0, 1));
         m_d <= 8'($urandom);
      end
   end

   assign i_alu_valid = (m_v | force_v) & ~kill;
   assign i_alu_data  = m_d;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Evaluate the current cycle (inputs already set), then advance one clock.
   task automatic cycle();
      logic [10:0] e;
      if (i_cmd_valid && o_cmd_ready) begin
         exp_q.push_back({alu_fn(i_cmd_inst, i_cmd_a, i_cmd_b), i_cmd_inst});
         n_acc++;
      end
      if (o_alu_valid) n_iss++;
      else check("alu_idle_zero", {13'd0, o_alu_inst, o_alu_a, o_alu_b}, 32'd0);
      if (o_res_valid && i_res_ready) begin
         if (exp_q.size() == 0) begin
            check("res_unexpected_valid", {31'd0, o_res_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("res_data", {24'd0, o_res_data}, {24'd0, e[10:3]});
            check("res_inst", {29'd0, o_res_inst}, {29'd0, e[2:0]});
         end
         log_q.push_back({o_res_data, o_res_inst});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_cmd();
      i_cmd_inst = 3'($urandom);
      i_cmd_a    = 8'($urandom);
      i_cmd_b    = 8'($urandom);
   endtask

   task automatic set_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      i_cmd_valid = 1'b1;
      i_cmd_inst  = op;
      i_cmd_a     = a;
      i_cmd_b     = b;
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic drain(input int max_cycles);
      i_cmd_valid = 1'b0;
      i_res_ready = 1'b1;
      for (int c = 0; c < max_cycles; c++) begin
         if (exp_q.size() == 0) break;
         cycle();
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      bit acc;
      int sent;

      i_rst       = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd_inst  = '0;
      i_cmd_a     = '0;
      i_cmd_b     = '0;
      i_res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;

      // Reset state
      check("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
      check("rst_alu_valid", {31'd0, o_alu_valid}, 32'd0);
      check("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
      check("rst_err", {31'd0, o_err}, 32'd0);
      check("rst_alu_data", {13'd0, o_alu_inst, o_alu_a, o_alu_b}, 32'd0);
      check("rst_res_data", {21'd0, o_res_data, o_res_inst}, 32'd0);

      // Minimum latency: accept C0, issue C1, result visible C3
      set_cmd(ADD, 8'h20, 8'h10);
      cycle();
      i_cmd_valid = 1'b0;
      check("lat_c1_alu_valid", {31'd0, o_alu_valid}, 32'd1);
      check("lat_c1_alu_op", {13'd0, o_alu_inst, o_alu_a, o_alu_b}, {13'd0, 3'd0, 8'h20, 8'h10});
      cycle();
      check("lat_c2_res_valid", {31'd0, o_res_valid}, 32'd0);
      cycle();
      check("lat_c3_res_valid", {31'd0, o_res_valid}, 32'd1);
      check("lat_c3_res", {21'd0, o_res_data, o_res_inst}, {21'd0, 8'h30, 3'd0});
      drain(10);

      // Back-to-back directed commands
      log_q.delete();
      i_res_ready = 1'b1;
      set_cmd(ADD, 8'h7F, 8'h01);
      cycle();
      set_cmd(MUL, 8'h20, 8'h40);
      cycle();
      set_cmd(MIN, 8'h90, 8'h10);
      cycle();
      drain(20);
      check("b2b_count", 32'(log_q.size()), 32'd3);
      check("b2b_r0", {21'd0, log_q[0]}, {21'd0, 8'h7F, 3'd0});
      check("b2b_r1", {21'd0, log_q[1]}, {21'd0, 8'h40, 3'd2});
      check("b2b_r2", {21'd0, log_q[2]}, {21'd0, 8'h90, 3'd7});

      // Backpressure: result FIFO stalled, 10 commands offered
      i_res_ready = 1'b0;
      n_acc = 0;
      n_iss = 0;
      sent  = 0;
      rand_cmd();
      i_cmd_valid = 1'b1;
      for (int c = 0; c < 14; c++) begin
         acc = i_cmd_valid && o_cmd_ready;
         cycle();
         if (acc) begin
            sent++;
            rand_cmd();
         end
         i_cmd_valid = (sent < 10);
      end
      check("bp_accepted", 32'(n_acc), 32'd8);
      check("bp_issued", 32'(n_iss), 32'd4);
      check("bp_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
      log_q.delete();
      drain(40);
      check("bp_results", 32'(log_q.size()), 32'd8);

      // Result FIFO push and pop together at count 1
      i_res_ready = 1'b1;
      found = 1'b0;
      rand_cmd();
      i_cmd_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (dut.w_res_count == 3'd1 && o_res_valid && i_alu_valid && dut.r_inflight) begin
            cycle();
            check("res_cnt_hold", 32'(dut.w_res_count), 32'd1);
            found = 1'b1;
            break;
         end
         acc = o_cmd_ready;
         cycle();
         if (acc) rand_cmd();
      end
      check("res_pushpop_seen", {31'd0, found}, 32'd1);

      // Command FIFO push and pop together at count DEPTH-1
      i_res_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         acc = o_cmd_ready;
         cycle();
         if (acc) rand_cmd();
      end
      i_res_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (dut.w_cmd_count == 3'd3 && o_cmd_ready && o_alu_valid) begin
            cycle();
            check("cmd_cnt_hold", 32'(dut.w_cmd_count), 32'd3);
            found = 1'b1;
            break;
         end
         acc = o_cmd_ready;
         cycle();
         if (acc) rand_cmd();
      end
      check("cmd_pushpop_seen", {31'd0, found}, 32'd1);
      drain(40);

      // Missing ALU result sets sticky error
      set_cmd(SUB, 8'h10, 8'h05);
      cycle();
      i_cmd_valid = 1'b0;
      check("err_issue", {31'd0, o_alu_valid}, 32'd1);
      cycle();
      kill = 1'b1;
      cycle();
      kill = 1'b0;
      void'(exp_q.pop_back());
      check("err_set", {31'd0, o_err}, 32'd1);
      check("err_no_result", {31'd0, o_res_valid}, 32'd0);
      set_cmd(XNOR, 8'h3C, 8'h0F);
      cycle();
      drain(10);
      check("err_held", {31'd0, o_err}, 32'd1);
      do_reset();
      check("err_cleared", {31'd0, o_err}, 32'd0);

      // Mid-operation reset with 3 queued and 1 in flight
      i_res_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         rand_cmd();
         i_cmd_valid = 1'b1;
         cycle();
      end
      i_res_ready = 1'b1;
      rand_cmd();
      cycle();
      i_res_ready = 1'b0;
      i_cmd_valid = 1'b0;
      cycle();
      check("pre_rst_cmd_cnt", 32'(dut.w_cmd_count), 32'd3);
      check("pre_rst_inflight", {31'd0, dut.r_inflight}, 32'd1);
      i_rst   = 1'b1;
      @(posedge clk);
      #1;
      i_rst   = 1'b0;
      force_v = 1'b1;
      exp_q.delete();
      check("post_rst_res_valid", {31'd0, o_res_valid}, 32'd0);
      check("post_rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
      i_res_ready = 1'b1;
      cycle();
      force_v = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("post_rst_no_stale", {31'd0, o_res_valid}, 32'd0);
         cycle();
      end
      check("post_rst_err", {31'd0, o_err}, 32'd0);

      // Randomized traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         if (!i_cmd_valid || o_cmd_ready) begin
            rand_cmd();
            i_cmd_valid = 1'($urandom_range(0, 3) != 0);
         end
         i_res_ready = 1'($urandom_range(0, 2) != 0);
         cycle();
      end
      drain(200);
      check("final_res_valid", {31'd0, o_res_valid}, 32'd0);
      check("final_err", {31'd0, o_err}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
